flash_write_sched: RTL and testbench
====================================

// Module: flash_write_sched
// PURPOSE
//  Page-aware write sequencer in front of the SPI-flash controller op port.
//  Accepts one long write request (start address, byte count) and splits it into page-program chunks.
//  No chunk crosses a P_PAGE_BYTES boundary or exceeds P_PAGE_BYTES.
//  Each chunk is issued on the controller op handshake; the next chunk waits for that chunk's completion pulse.
//  Write payload bytes flow to the controller outside this block; this block only sequences commands.
// PARAMETERS
//  P_PAGE_BYTES  256      flash page size in bytes; power of two, <=256 (fits 9-bit op_num)
//  P_TIMEOUT     1000000  max cycles waiting for i_op_done per chunk before abort
//  P_OP_WRITE    2        op-type code driven on o_op_typ for page program
// PORTS
//  i_clk          in   1   system clock
//  i_rst          in   1   synchronous reset, active-high
//  i_req_addr     in   24  start byte address of write request
//  i_req_len      in   16  byte count, 1..65535; 0 is illegal
//  i_req_valid    in   1   request valid
//  o_req_ready    out  1   ready for new request (high only in IDLE)
//  o_op_typ       out  2   constant P_OP_WRITE
//  o_op_addr      out  24  chunk start address
//  o_op_num       out  9   chunk byte count, 1..P_PAGE_BYTES
//  o_op_valid     out  1   chunk command valid
//  i_op_ready     in   1   controller accepts command when valid&ready
//  i_op_done      in   1   1-cycle pulse: chunk program incl. busy-poll finished
//  o_busy         out  1   high from request accept until o_done/o_err
//  o_done         out  1   1-cycle pulse: all chunks completed
//  o_err          out  1   1-cycle pulse: illegal request or timeout
// BEHAVIOUR
//  Clock and reset
//   - Single clock domain.
//   - Reset is synchronous: on any edge with i_rst=1, all state and counters clear.
//   - Reset values: o_req_ready=1; o_op_valid=0; o_busy=0; o_done=0; o_err=0.
//   - Reset values: o_op_addr=0; o_op_num=0; o_op_typ=P_OP_WRITE.
//   - Reset mid-operation abandons the request silently: no o_done, no o_err.
//  States and transitions
//   - IDLE -> CHECK on accept (i_req_valid & o_req_ready); latch addr and len, o_busy=1.
//   - CHECK: if len==0 or addr+len > 2^24 (25-bit sum), pulse o_err and return to IDLE; otherwise go to CALC.
//   - CALC: room = P_PAGE_BYTES - addr[log2(P_PAGE_BYTES)-1:0]; chunk = min(remaining, room).
//     Load o_op_addr/o_op_num, then go to ISSUE.
//   - ISSUE: hold o_op_valid=1 with all o_op_* stable until i_op_ready, then go to WAIT.
//     On the handshake: addr += chunk, remaining -= chunk.
//   - WAIT: timeout counter clears on entry and increments each cycle.
//     i_op_done -> CALC if remaining!=0, otherwise DONE.
//     Counter reaching P_TIMEOUT-1 without done -> pulse o_err, go to IDLE.
//   - DONE: pulse o_done, go to IDLE (o_req_ready=1 the same cycle o_done=1).
//  Latency
//   - Accept at cycle T -> first o_op_valid at T+3.
//   - i_op_done at D -> next o_op_valid at D+2, or o_done at D+1 for the last chunk.
//  Boundary conditions
//   - i_op_done outside WAIT, including in the handshake cycle, is ignored. The controller must pulse it after acceptance.
//   - i_req_valid while busy: not accepted; the requester holds it.
//   - Address exactly page-aligned: the first chunk is min(len, P_PAGE_BYTES).
//   - Request ending exactly at 0xFFFFFF: legal, since addr+len == 2^24 is allowed.
//   - remaining and address arithmetic are unsigned, with no wrap past 24 bits (guaranteed by CHECK).
// STRUCTURE
//  Shared package flash_pkg holds:
//   - op-type codes (OP_CMD=0, OP_READ=1, OP_WRITE=2)
//   - page size
//   - sched state enum (IDLE, CHECK, CALC, ISSUE, WAIT, DONE)
//  Natural sub-module: flash_chunk_calc, a registered min(remaining, page room) calculator used in CALC.
//  FSM, counters and handshake logic stay in flash_write_sched.
// TESTING
//  1. addr=0x000010, len=16 -> one chunk (0x000010, 16); o_done 1 cycle after i_op_done.
//  2. addr=0x0000F0, len=300 -> chunks (0x0000F0,16), (0x000100,256), (0x000200,28); exactly one o_done.
//  3. len=0 -> o_err pulse 1 cycle after accept; o_op_valid never asserted; o_req_ready back to 1.
//  4. addr=0xFFFF00, len=512 -> o_err, no chunk issued.
//     addr=0xFFFF00, len=256 -> one chunk (0xFFFF00, 256), o_done.
//  5. i_op_ready held low 10 cycles -> o_op_* stable throughout.
//     i_op_done then withheld P_TIMEOUT cycles -> o_err, state IDLE.
//  6. i_rst=1 for 1 cycle while in WAIT of chunk 2 -> all outputs at reset values next cycle.
//     No o_done/o_err; a new request is then accepted normally.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared definitions for the SPI-flash front-end blocks: op-type codes,
// geometry, scheduler state encoding and request arithmetic helpers.
package flash_pkg;

    localparam int ADDR_W     = 24;
    localparam int LEN_W      = 16;
    localparam int NUM_W      = 9;
    localparam int PAGE_BYTES = 256;

    localparam logic [1:0] OP_CMD   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        CALC  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } sched_state_e;

    // A request is illegal when empty or when it would run past the top of the 24-bit space.
    function automatic logic req_illegal(input logic [ADDR_W-1:0] addr,
                                         input logic [LEN_W-1:0]  len);
        logic [ADDR_W:0] end_s;
        end_s = {1'b0, addr} + {{(ADDR_W-LEN_W+1){1'b0}}, len};
        return (len == {LEN_W{1'b0}}) || (end_s > {1'b1, {ADDR_W{1'b0}}});
    endfunction

    // Bytes left between addr and the next page boundary (1..page).
    function automatic logic [NUM_W-1:0] page_room(input logic [ADDR_W-1:0] addr,
                                                   input logic [NUM_W-1:0]  page);
        logic [NUM_W-1:0] off_s;
        off_s = addr[NUM_W-1:0] & (page - NUM_W'(1));
        return page - off_s;
    endfunction

endpackage

// File: rtl/flash_chunk_calc.sv
// Registered chunk-size calculator: min(remaining bytes, room left in the current page).
module flash_chunk_calc
    import flash_pkg::*;
#(
    parameter int P_PAGE_BYTES = PAGE_BYTES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  rem_i,
    output logic [NUM_W-1:0]  chunk_o
);

    localparam logic [NUM_W-1:0] PAGE_C = NUM_W'(P_PAGE_BYTES);

    logic [NUM_W-1:0] room_s;
    logic [NUM_W-1:0] chunk_d;
    logic [NUM_W-1:0] chunk_q;

    // Pick the smaller of the page room and the bytes still to be written.
    always_comb begin
        room_s = page_room(addr_i, PAGE_C);
        if (rem_i < {{(LEN_W-NUM_W){1'b0}}, room_s}) begin
            chunk_d = rem_i[NUM_W-1:0];
        end else begin
            chunk_d = room_s;
        end
    end

    // Result register, sampled by the scheduler while it sits in CALC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chunk_q <= {NUM_W{1'b0}};
        end else begin
            chunk_q <= chunk_d;
        end
    end

    assign chunk_o = chunk_q;

endmodule

// File: rtl/flash_write_sched.sv
// Page-aware write sequencer: splits one long write request into page-program
// commands and issues them one at a time on the flash controller op port.
module flash_write_sched
    import flash_pkg::*;
#(
    parameter int         P_PAGE_BYTES = PAGE_BYTES,
    parameter int         P_TIMEOUT    = 1000000,
    parameter logic [1:0] P_OP_WRITE   = OP_WRITE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [LEN_W-1:0]  i_req_len,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    output logic [1:0]        o_op_typ,
    output logic [ADDR_W-1:0] o_op_addr,
    output logic [NUM_W-1:0]  o_op_num,
    output logic              o_op_valid,
    input  logic              i_op_ready,
    input  logic              i_op_done,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int              TMO_W    = $clog2(P_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_TIMEOUT - 1);

    sched_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [ADDR_W-1:0] op_addr_q;
    logic [NUM_W-1:0]  op_num_q;
    logic              op_valid_q;
    logic              req_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [NUM_W-1:0]  chunk_s;
    logic              accept_s;

    assign accept_s = i_req_valid & req_ready_q;

    flash_chunk_calc #(
        .P_PAGE_BYTES (P_PAGE_BYTES)
    ) u_chunk_calc (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .addr_i  (addr_q),
        .rem_i   (rem_q),
        .chunk_o (chunk_s)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            rem_q       <= {LEN_W{1'b0}};
            op_addr_q   <= {ADDR_W{1'b0}};
            op_num_q    <= {NUM_W{1'b0}};
            op_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= {TMO_W{1'b0}};
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // DONE already shows ready, so it accepts exactly like IDLE.
                IDLE, DONE: begin
                    if (accept_s) begin
                        addr_q      <= i_req_addr;
                        rem_q       <= i_req_len;
                        err_q       <= req_illegal(i_req_addr, i_req_len);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= CHECK;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                // err_q was loaded with the legality verdict at accept time.
                CHECK: begin
                    if (err_q) begin
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    op_addr_q  <= addr_q;
                    op_num_q   <= chunk_s;
                    op_valid_q <= 1'b1;
                    state_q    <= ISSUE;
                end
                ISSUE: begin
                    if (i_op_ready) begin
                        op_valid_q <= 1'b0;
                        addr_q     <= addr_q + ADDR_W'(op_num_q);
                        rem_q      <= rem_q - LEN_W'(op_num_q);
                        tmo_q      <= {TMO_W{1'b0}};
                        state_q    <= WAIT;
                    end else begin
                        state_q <= ISSUE;
                    end
                end
                WAIT: begin
                    if (i_op_done) begin
                        if (rem_q != {LEN_W{1'b0}}) begin
                            state_q <= CALC;
                        end else begin
                            done_q      <= 1'b1;
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= DONE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q       <= 1'b1;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    op_valid_q  <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_op_typ    = P_OP_WRITE;
    assign o_op_addr   = op_addr_q;
    assign o_op_num    = op_num_q;
    assign o_op_valid  = op_valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_flash_write_sched.sv
// Randomised self-checking bench for flash_write_sched against a chunk-list reference model.
module tb_flash_write_sched;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op_typ;
    logic [23:0] op_addr;
    logic [8:0]  op_num;
    logic        op_valid;
    logic        op_ready;
    logic        op_done;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always #5 clk = ~clk;

    flash_write_sched #(
        .P_PAGE_BYTES (256),
        .P_TIMEOUT    (TMO),
        .P_OP_WRITE   (2'd2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_addr  (req_addr),
        .i_req_len   (req_len),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .o_op_typ    (op_typ),
        .o_op_addr   (op_addr),
        .o_op_num    (op_num),
        .o_op_valid  (op_valid),
        .i_op_ready  (op_ready),
        .i_op_done   (op_done),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_valid"}, op_valid, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   err, 0);
        chk({tag, "_addr"},  op_addr, 0);
        chk({tag, "_num"},   op_num, 0);
        chk({tag, "_typ"},   op_typ, 2);
    endtask

    // mode: 0 normal, 1 withhold done at chunk abort_idx, 2 reset in WAIT of chunk abort_idx.
    task automatic run_req(input logic [23:0] a, input logic [15:0] len, input int mode,
                           input int abort_idx, input int st_lo, input int st_hi);
        int unsigned ua, ul, ma, rem, room, n;
        int unsigned exp_addr[$];
        int unsigned exp_num[$];
        bit illegal;
        int d0, e0, stall, k, last;
        ua = a;
        ul = len;
        illegal = (ul == 0) || (ua + ul > 32'h0100_0000);
        if (!illegal) begin
            ma  = ua;
            rem = ul;
            while (rem > 0) begin
                room = 256 - (ma % 256);
                n = (rem < room) ? rem : room;
                exp_addr.push_back(ma);
                exp_num.push_back(n);
                ma  += n;
                rem -= n;
            end
        end
        d0 = done_cnt;
        e0 = err_cnt;
        chk("idle_ready", req_ready, 1);
        req_addr  = a;
        req_len   = len;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        if (illegal) begin
            chk("err_pulse", err, 1);
            chk("err_no_valid", op_valid, 0);
            step();
            chk("err_clear", err, 0);
            chk("err_ready", req_ready, 1);
            chk("err_busy", busy, 0);
            chk("err_valid", op_valid, 0);
            chk("err_count", err_cnt - e0, 1);
            chk("err_no_done", done_cnt - d0, 0);
            return;
        end
        chk("acc_busy", busy, 1);
        chk("acc_ready", req_ready, 0);
        chk("acc_valid", op_valid, 0);
        step();
        chk("lat_valid_early", op_valid, 0);
        step();
        last = exp_addr.size() - 1;
        for (int c = 0; c <= last; c++) begin
            chk("op_valid", op_valid, 1);
            chk("op_addr", op_addr, exp_addr[c]);
            chk("op_num", op_num, exp_num[c]);
            chk("op_typ", op_typ, 2);
            stall = $urandom_range(st_hi, st_lo);
            for (int s = 0; s < stall; s++) begin
                req_valid = $urandom_range(1, 0);
                req_addr  = $urandom;
                req_len   = 16'd1;
                step();
                chk("stall_valid", op_valid, 1);
                chk("stall_addr", op_addr, exp_addr[c]);
                chk("stall_num", op_num, exp_num[c]);
                chk("stall_ready", req_ready, 0);
            end
            req_valid = 1'b0;
            op_ready  = 1'b1;
            op_done   = ($urandom_range(3, 0) == 0);
            step();
            op_ready = 1'b0;
            op_done  = 1'b0;
            chk("hs_drop", op_valid, 0);
            if (mode == 1 && c == abort_idx) begin
                k = 0;
                while (!err && k < TMO + 10) begin
                    step();
                    k++;
                end
                chk("tmo_seen", err, 1);
                chk("tmo_not_early", (k >= TMO - 1), 1);
                chk("tmo_not_late", (k <= TMO + 1), 1);
                step();
                chk("tmo_ready", req_ready, 1);
                chk("tmo_busy", busy, 0);
                chk("tmo_valid", op_valid, 0);
                chk("tmo_err_count", err_cnt - e0, 1);
                chk("tmo_no_done", done_cnt - d0, 0);
                return;
            end
            if (mode == 2 && c == abort_idx) begin
                repeat ($urandom_range(3, 0)) step();
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk_reset_vals("midrst");
                repeat (3) step();
                chk("midrst_no_done", done_cnt - d0, 0);
                chk("midrst_no_err", err_cnt - e0, 0);
                return;
            end
            k = $urandom_range(5, 0);
            repeat (k) begin
                step();
                chk("wait_no_valid", op_valid, 0);
            end
            op_done = 1'b1;
            step();
            op_done = 1'b0;
            if (c == last) begin
                chk("done_pulse", done, 1);
                chk("done_ready", req_ready, 1);
                chk("done_busy", busy, 0);
                step();
                chk("done_clear", done, 0);
            end else begin
                chk("next_not_yet", op_valid, 0);
                step();
            end
        end
        chk("done_count", done_cnt - d0, 1);
        chk("no_err", err_cnt - e0, 0);
    endtask

    initial begin
        logic [31:0] r;
        logic [23:0] ra;
        logic [15:0] rl;
        int          sel;
        rst       = 1'b1;
        req_addr  = 24'h0;
        req_len   = 16'h0;
        req_valid = 1'b0;
        op_ready  = 1'b0;
        op_done   = 1'b0;
        step();
        step();
        chk_reset_vals("rst");
        rst = 1'b0;
        step();

        run_req(24'h000010, 16'd16,  0, 0, 0, 2);
        run_req(24'h0000F0, 16'd300, 0, 0, 0, 3);
        run_req(24'h001234, 16'd0,   0, 0, 0, 0);
        run_req(24'hFFFF00, 16'd512, 0, 0, 0, 0);
        run_req(24'hFFFF00, 16'd256, 0, 0, 0, 2);
        run_req(24'hFFFFFF, 16'd1,   0, 0, 0, 1);
        run_req(24'hFFFFFF, 16'd2,   0, 0, 0, 1);
        run_req(24'h000300, 16'd600, 0, 0, 10, 10);
        run_req(24'h000400, 16'd16,  1, 0, 10, 10);
        run_req(24'h0000F0, 16'd300, 2, 1, 0, 2);
        run_req(24'h000005, 16'd20,  0, 0, 0, 2);
        run_req(24'h000100, 16'hFFFF, 0, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            r   = $urandom;
            sel = $urandom_range(9, 0);
            if (sel < 2) begin
                ra = 24'hFFFFFF - 24'($urandom_range(600, 0));
            end else begin
                case ($urandom_range(3, 0))
                    0:       ra = {r[23:8], 8'h00};
                    1:       ra = {r[23:8], 8'h01};
                    2:       ra = {r[23:8], 8'hFF};
                    default: ra = r[23:0];
                endcase
            end
            case ($urandom_range(9, 0))
                0:       rl = 16'd0;
                1:       rl = 16'd256;
                2:       rl = 16'($urandom_range(8, 1));
                default: rl = 16'($urandom_range(700, 1));
            endcase
            if ($urandom_range(14, 0) == 0) begin
                run_req(ra, rl, 1, 0, 0, 2);
            end else begin
                run_req(ra, rl, 0, 0, 0, 3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
